ads131a0x_frame_reader: RTL and testbench

Parametrised SPI frame reader for the ADS131A0X ADC family. The FPGA is the SPI master. On each DRDY falling edge the block clocks out one full device frame: a status word followed by NUM_CH channel words. It presents the captured status and channel samples in parallel with a one-cycle valid strobe. It sits between the ADC pins and the top-level sample-processing and LED-status logic, all clocked by system_clock (50 MHz).

---
 rtl/ads131a0x_frame_reader.sv | 143 ++++++++++++++
 tb/tb_ads131a0x_frame_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads131a0x_frame_reader.sv
// SPI master that reads one ADS131A0x frame (status word + NUM_CH channel words)
// per DRDY falling edge and presents the captured words in parallel.
module ads131a0x_frame_reader #(
    parameter int          NUM_CH    = 4,
    parameter int          WORD_BITS = 24,
    parameter int          CLK_DIV   = 2,
    parameter logic [15:0] CMD_WORD  = 16'h0000
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   drdy_n,
    input  logic                   spi_miso,
    output logic                   spi_sclk,
    output logic                   spi_cs_n,
    output logic                   spi_mosi,
    output logic [15:0]            status_word,
    output logic [NUM_CH*24-1:0]   ch_data,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int TOTAL_BITS = (NUM_CH + 1) * WORD_BITS;
    localparam int HALF_W     = $clog2(2 * TOTAL_BITS + 1);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic                  drdy_meta;
    logic                  drdy_sync;
    logic                  drdy_prev;
    logic                  drdy_fall;
    logic [DIV_W-1:0]      div_cnt;
    logic                  div_done;
    logic [HALF_W-1:0]     half_cnt;
    logic                  last_half;
    logic [TOTAL_BITS-1:0] rx_sr;
    logic [15:0]           cmd_sr;

    assign drdy_fall = ~drdy_sync & drdy_prev;
    assign div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_half = (half_cnt == HALF_W'(2 * TOTAL_BITS - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (drdy_fall && enable) state_next = SETUP;
            SETUP:   if (div_done) state_next = SHIFT;
            SHIFT:   if (div_done && last_half) state_next = HOLD;
            HOLD:    if (div_done) state_next = GAP;
            GAP:     if (div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state       <= IDLE;
            drdy_meta   <= 1'b1;
            drdy_sync   <= 1'b1;
            drdy_prev   <= 1'b1;
            div_cnt     <= '0;
            half_cnt    <= '0;
            rx_sr       <= '0;
            cmd_sr      <= '0;
            spi_sclk    <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            status_word <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            drdy_meta   <= drdy_n;
            drdy_sync   <= drdy_meta;
            drdy_prev   <= drdy_sync;
            frame_valid <= 1'b0;

            // A new overrun event takes priority over a simultaneous clear.
            if (drdy_fall && state != IDLE) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (state == IDLE || div_done) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            case (state)
                IDLE: begin
                    if (drdy_fall && enable) begin
                        spi_cs_n <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= 1'b0;
                        half_cnt <= '0;
                        cmd_sr   <= CMD_WORD;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        half_cnt <= half_cnt + HALF_W'(1);
                        spi_sclk <= ~spi_sclk;
                        // Even half-periods end in a rising edge, odd ones in a falling edge.
                        if (!half_cnt[0]) begin
                            spi_mosi <= cmd_sr[15];
                            cmd_sr   <= {cmd_sr[14:0], 1'b0};
                        end else begin
                            rx_sr <= {rx_sr[TOTAL_BITS-2:0], spi_miso};
                        end
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        spi_cs_n    <= 1'b1;
                        frame_valid <= 1'b1;
                        status_word <= rx_sr[TOTAL_BITS-1 -: 16];
                        for (int n = 0; n < NUM_CH; n++) begin
                            ch_data[24*n +: 24] <= rx_sr[TOTAL_BITS-1-(n+1)*WORD_BITS -: 24];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ads131a0x_frame_reader.sv
// Bench for ads131a0x_frame_reader: an ADC pin model feeds random and directed
// frames, and a word-level reference computes the expected parallel outputs.
module tb_ads131a0x_frame_reader;

    localparam int          A_BITS = 120;
    localparam int          B_BITS = 96;
    localparam logic [15:0] A_CMD  = 16'h0655;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    // Instance A: 4 x 24-bit words, CLK_DIV=2, non-null command
    logic        en_a = 1'b1, drdy_a = 1'b1, miso_a = 1'b0, clr_a = 1'b0;
    logic        sclk_a, cs_a, mosi_a, fv_a, busy_a, ovr_a;
    logic [15:0] st_a;
    logic [95:0] ch_a;

    // Instance B: 2 x 32-bit words, CLK_DIV=1
    logic        en_b = 1'b1, drdy_b = 1'b1, miso_b = 1'b0, clr_b = 1'b0;
    logic        sclk_b, cs_b, mosi_b, fv_b, busy_b, ovr_b;
    logic [15:0] st_b;
    logic [47:0] ch_b;

    ads131a0x_frame_reader #(.NUM_CH(4), .WORD_BITS(24), .CLK_DIV(2), .CMD_WORD(A_CMD)) dut_a (
        .system_clock(clk), .reset(reset), .enable(en_a), .drdy_n(drdy_a),
        .spi_miso(miso_a), .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
        .status_word(st_a), .ch_data(ch_a), .frame_valid(fv_a), .busy(busy_a),
        .overrun(ovr_a), .overrun_clr(clr_a)
    );

    ads131a0x_frame_reader #(.NUM_CH(2), .WORD_BITS(32), .CLK_DIV(1), .CMD_WORD(16'h0000)) dut_b (
        .system_clock(clk), .reset(reset), .enable(en_b), .drdy_n(drdy_b),
        .spi_miso(miso_b), .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
        .status_word(st_b), .ch_data(ch_b), .frame_valid(fv_b), .busy(busy_b),
        .overrun(ovr_b), .overrun_clr(clr_b)
    );

    int checks = 0;
    int errors = 0;

    // ADC pin model and bus monitor for A
    logic [A_BITS-1:0] tx_a = '0;
    logic [A_BITS-1:0] mosi_bits_a = '0;
    logic prev_sclk_a = 1'b0, prev_cs_a = 1'b1, prev_mosi_a = 1'b0;
    int   rise_a = 0, cs_low_a = 0, valid_a = 0, fall_a = 0, coinc_err_a = 0, mosi_err_a = 0;

    always @(negedge clk) begin
        if (prev_cs_a && !cs_a) begin
            rise_a      = 0;
            cs_low_a    = 0;
            mosi_bits_a = '0;
            fall_a++;
        end
        if (!cs_a) cs_low_a++;
        if (sclk_a && !prev_sclk_a) begin
            if (rise_a < A_BITS) miso_a = tx_a[A_BITS-1-rise_a];
            mosi_bits_a = {mosi_bits_a[A_BITS-2:0], mosi_a};
            rise_a++;
        end
        if (mosi_a !== prev_mosi_a && !(sclk_a && !prev_sclk_a)) mosi_err_a++;
        if (fv_a) begin
            valid_a++;
            if (!(cs_a && !prev_cs_a)) coinc_err_a++;
        end
        prev_sclk_a = sclk_a;
        prev_cs_a   = cs_a;
        prev_mosi_a = mosi_a;
    end

    // ADC pin model and bus monitor for B
    logic [B_BITS-1:0] tx_b = '0;
    logic prev_sclk_b = 1'b0, prev_cs_b = 1'b1;
    int   rise_b = 0, cs_low_b = 0, valid_b = 0;

    always @(negedge clk) begin
        if (prev_cs_b && !cs_b) begin
            rise_b   = 0;
            cs_low_b = 0;
        end
        if (!cs_b) cs_low_b++;
        if (sclk_b && !prev_sclk_b) begin
            if (rise_b < B_BITS) miso_b = tx_b[B_BITS-1-rise_b];
            rise_b++;
        end
        if (fv_b) valid_b++;
        prev_sclk_b = sclk_b;
        prev_cs_b   = cs_b;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: words as the ADC sends them, and the outputs they must produce
    logic [23:0] wa[5];
    logic [31:0] wb[3];
    logic [15:0] exp_st_a, exp_st_b;
    logic [95:0] exp_ch_a;
    logic [47:0] exp_ch_b;
    int          v0_a, f0_a, v0_b;

    task automatic random_words_a();
        for (int i = 0; i < 5; i++) wa[i] = 24'($urandom);
    endtask

    task automatic start_a();
        logic [A_BITS-1:0] tx;
        for (int i = 0; i < 5; i++) tx[A_BITS-1-24*i -: 24] = wa[i];
        exp_st_a = wa[0][23:8];
        for (int n = 0; n < 4; n++) exp_ch_a[24*n +: 24] = wa[n+1];
        tx_a = tx;
        v0_a = valid_a;
        f0_a = fall_a;
        drdy_a = 1'b0;
        tick(4);
        drdy_a = 1'b1;
    endtask

    task automatic wait_valid_a();
        int n = 0;
        while (valid_a == v0_a && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_a(input string tag);
        wait_valid_a();
        check({tag, " valid"},  128'(valid_a - v0_a), 128'(1));
        check({tag, " status"}, 128'(st_a), 128'(exp_st_a));
        check({tag, " ch"},     128'(ch_a), 128'(exp_ch_a));
        check({tag, " rises"},  128'(rise_a), 128'(A_BITS));
        check({tag, " cs_low"}, 128'(cs_low_a), 128'(2 * (2 * A_BITS + 2)));
        check({tag, " mosi"},   128'(mosi_bits_a), 128'({A_CMD, 104'h0}));
    endtask

    task automatic frame_b(input string tag);
        logic [B_BITS-1:0] tx;
        int n = 0;
        for (int i = 0; i < 3; i++) tx[B_BITS-1-32*i -: 32] = wb[i];
        exp_st_b = wb[0][31:16];
        for (int c = 0; c < 2; c++) exp_ch_b[24*c +: 24] = wb[c+1][31:8];
        tx_b = tx;
        v0_b = valid_b;
        drdy_b = 1'b0;
        tick(4);
        drdy_b = 1'b1;
        while (valid_b == v0_b && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"},  128'(valid_b - v0_b), 128'(1));
        check({tag, " status"}, 128'(st_b), 128'(exp_st_b));
        check({tag, " ch"},     128'(ch_b), 128'(exp_ch_b));
        check({tag, " rises"},  128'(rise_b), 128'(B_BITS));
        check({tag, " cs_low"}, 128'(cs_low_b), 128'(2 * B_BITS + 2));
    endtask

    initial begin
        int n;

        // Reset values
        tick(3);
        check("rst cs_n",   128'(cs_a), 128'(1));
        check("rst sclk",   128'(sclk_a), 128'(0));
        check("rst mosi",   128'(mosi_a), 128'(0));
        check("rst valid",  128'(fv_a), 128'(0));
        check("rst busy",   128'(busy_a), 128'(0));
        check("rst ovr",    128'(ovr_a), 128'(0));
        check("rst status", 128'(st_a), 128'(0));
        check("rst ch",     128'(ch_a), 128'(0));
        reset = 1'b0;
        tick(5);

        // Directed extreme sample values
        wa[0] = 24'h220000; wa[1] = 24'h000001; wa[2] = 24'h7FFFFF;
        wa[3] = 24'h800000; wa[4] = 24'hFFFFFF;
        start_a();
        finish_a("directed");
        tick(10);

        for (int r = 0; r < 3; r++) begin
            random_words_a();
            start_a();
            finish_a("random");
            tick($urandom_range(5, 20));
        end

        // Second DRDY edge mid-frame: overrun, frame still completes once
        random_words_a();
        start_a();
        tick(46);
        drdy_a = 1'b0;
        tick(4);
        drdy_a = 1'b1;
        finish_a("overrun frame");
        tick(40);
        check("overrun set",      128'(ovr_a), 128'(1));
        check("overrun one frame", 128'(fall_a - f0_a), 128'(1));
        check("overrun one valid", 128'(valid_a - v0_a), 128'(1));
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        tick(1);
        check("overrun clr", 128'(ovr_a), 128'(0));

        // enable low: DRDY edge ignored
        en_a = 1'b0;
        f0_a = fall_a;
        drdy_a = 1'b0;
        tick(4);
        drdy_a = 1'b1;
        tick(20);
        check("disabled cs_n",  128'(cs_a), 128'(1));
        check("disabled frames", 128'(fall_a - f0_a), 128'(0));
        check("disabled ovr",   128'(ovr_a), 128'(0));
        en_a = 1'b1;

        // enable dropped mid-frame: frame still finishes
        random_words_a();
        start_a();
        tick(30);
        en_a = 1'b0;
        finish_a("enable drop");
        en_a = 1'b1;
        tick(10);

        // Reset at the 37th SCLK rising edge aborts the frame
        random_words_a();
        start_a();
        n = 0;
        while (rise_a < 37 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort reached edge 37", 128'(rise_a), 128'(37));
        reset = 1'b1;
        tick(1);
        check("abort cs_n",   128'(cs_a), 128'(1));
        check("abort sclk",   128'(sclk_a), 128'(0));
        check("abort busy",   128'(busy_a), 128'(0));
        check("abort status", 128'(st_a), 128'(0));
        check("abort ch",     128'(ch_a), 128'(0));
        reset = 1'b0;
        tick(600);
        check("abort no valid", 128'(valid_a - v0_a), 128'(0));
        random_words_a();
        start_a();
        finish_a("after abort");
        tick(10);

        // 32-bit words with pad byte discarded
        wb[0] = 32'h220000A5; wb[1] = 32'hABCDEFA5; wb[2] = 32'h123456A5;
        frame_b("wide directed");
        check("wide ch pair", 128'(ch_b), 128'({24'h123456, 24'hABCDEF}));
        tick(5);
        for (int i = 0; i < 3; i++) wb[i] = $urandom;
        frame_b("wide random");
        tick(5);

        check("mosi only on rising", 128'(mosi_err_a), 128'(0));
        check("valid with cs rise",  128'(coinc_err_a), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
